// File: rtl/button_counter_pkg.sv
// Shared types and sizing helpers for the button-driven counter.
package button_counter_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

    localparam int CNT_W = 8;

    function automatic int timer_width(input int hold_cycles, input int repeat_cycles);
        int m;
        m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int TIMER_W = timer_width(20, 8);

endpackage

// File: rtl/button_conditioner.sv
// One raw button -> synchronised, debounced, edge-detected one-cycle pulse with optional auto-repeat.
module button_conditioner
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 20,
    parameter int REPEAT_CYCLES   = 8,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);

    logic [1:0]    sync_q;
    logic          s;
    logic          deb_q, deb_prev_q;
    logic [DW-1:0] dcnt_q;
    rep_state_t    state_q;
    logic [TW-1:0] tmr_q;
    logic          pulse_q;

    assign s       = sync_q[1];
    assign pulse_o = pulse_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            dcnt_q     <= '0;
        end else begin
            sync_q     <= {sync_q[0], btn_i};
            deb_prev_q <= deb_q;
            if (s == deb_q) begin
                dcnt_q <= '0;
            end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_q  <= s;
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_q + DW'(1);
            end
        end
    end

    // Release always wins over a due repeat pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (deb_q && !deb_prev_q) begin
                        pulse_q <= 1'b1;
                        tmr_q   <= '0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!deb_q) begin
                        state_q <= IDLE;
                    end else if (REPEAT_EN) begin
                        if (tmr_q == TW'(HOLD_CYCLES - 1)) begin
                            pulse_q <= 1'b1;
                            tmr_q   <= '0;
                            state_q <= REPEAT;
                        end else begin
                            tmr_q <= tmr_q + TW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (!deb_q) begin
                        state_q <= IDLE;
                    end else if (tmr_q == TW'(REPEAT_CYCLES - 1)) begin
                        pulse_q <= 1'b1;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_counter.sv
// Up/down/clear buttons drive a saturating or wrapping 8-bit count for the BCD display path.
module button_counter
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 20,
    parameter int REPEAT_CYCLES   = 8,
    parameter int MAX_COUNT       = 255,
    parameter bit WRAP            = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clr,
    output logic [CNT_W-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             step
);
    localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_COUNT);

    logic             up_p, dn_p, clr_p;
    logic [CNT_W-1:0] count_q, count_d;
    logic             step_q;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
                         .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
        u_up  (.clk(clk), .rst(rst), .btn_i(btn_up),   .pulse_o(up_p));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
                         .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
        u_dn  (.clk(clk), .rst(rst), .btn_i(btn_down), .pulse_o(dn_p));
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
                         .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
        u_clr (.clk(clk), .rst(rst), .btn_i(btn_clr),  .pulse_o(clr_p));

    always_comb begin
        count_d = count_q;
        if (clr_p) begin
            count_d = '0;
        end else if (up_p && !dn_p) begin
            if (count_q == MAXV) count_d = WRAP ? '0 : MAXV;
            else                 count_d = count_q + CNT_W'(1);
        end else if (dn_p && !up_p) begin
            if (count_q == '0) count_d = WRAP ? MAXV : '0;
            else               count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            step_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            step_q  <= (count_d != count_q);
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == MAXV);
    assign at_min = (count_q == '0);
    assign step   = step_q;

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter: a wrapping (MAX 99) and a saturating (MAX 255) instance share one set of buttons.
module tb_button_counter;
    localparam int NCYC = 8000;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic clk = 1'b0, rst = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_clr = 1'b0;
    logic [7:0] cnt_a, cnt_b;
    logic amax_a, amin_a, step_a, amax_b, amin_b, step_b;

    button_counter #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
                     .MAX_COUNT(99), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .count(cnt_a), .at_max(amax_a), .at_min(amin_a), .step(step_a));
    button_counter #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
                     .MAX_COUNT(255), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .count(cnt_b), .at_max(amax_b), .at_min(amin_b), .step(step_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int val; } exp_t;
    typedef struct { logic [2:0] m; int len; int exp_a; int exp_b; } vec_t;

    exp_t qa[$], qb[$];
    bit   up_p[NCYC], dn_p[NCYC], cl_p[NCYC];
    int   m_a = 0, m_b = 0;
    int   checks = 0, failures = 0;
    int   nv;
    bit   due_a, due_b;

    function automatic int next_val(input int cur, input int mx, input bit wrap,
                                    input bit u, input bit d, input bit c);
        if (c) return 0;
        if (u && !d) return (cur == mx) ? (wrap ? 0 : mx) : cur + 1;
        if (d && !u) return (cur == 0) ? (wrap ? mx : 0) : cur - 1;
        return cur;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic sb_cmp(input string nm, input logic stp, input logic [7:0] cv,
                          input bit due, input int ev);
        checks++;
        if (due) begin
            if (stp !== 1'b1 || cv !== 8'(ev)) begin
                failures++;
                $display("FAIL %s_step cyc=%0d step=%b count=%0d want step=1 count=%0d",
                         nm, cyc, stp, cv, ev);
            end
        end else if (stp !== 1'b0) begin
            failures++;
            $display("FAIL %s_nostep cyc=%0d step=%b count=%0d want step=0", nm, cyc, stp, cv);
        end
    endtask

    // Press seen at edge n gives pulses at n+6, n+26, then every 8, while the debounced level holds.
    task automatic mark(input int sel, input int n, input int len);
        int e;
        if (len < DEB) return;
        e = n + 6;
        while (e <= n + len + 5 && e < NCYC) begin
            case (sel)
                0: up_p[e] = 1'b1;
                1: dn_p[e] = 1'b1;
                default: cl_p[e] = 1'b1;
            endcase
            if (sel == 2) break;
            e += (e == n + 6) ? HOLD : REP;
        end
    endtask

    task automatic press(input logic [2:0] m, input int len);
        int n;
        @(posedge clk); #1;
        n = cyc + 1;
        btn_up = m[0]; btn_down = m[1]; btn_clr = m[2];
        for (int k = 0; k < 3; k++) if (m[k]) mark(k, n, len);
        repeat (len) @(posedge clk);
        #1;
        btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    endtask

    // Scoreboard: compare first, then let the model advance on this cycle's pulses.
    always @(negedge clk) begin
        if (rst) begin
            due_a = (qa.size() > 0) && (qa[0].cyc == cyc);
            sb_cmp("a", step_a, cnt_a, due_a, due_a ? qa[0].val : 0);
            if (due_a) void'(qa.pop_front());
            due_b = (qb.size() > 0) && (qb[0].cyc == cyc);
            sb_cmp("b", step_b, cnt_b, due_b, due_b ? qb[0].val : 0);
            if (due_b) void'(qb.pop_front());
            if (cyc < NCYC) begin
                nv = next_val(m_a, 99, 1'b1, up_p[cyc], dn_p[cyc], cl_p[cyc]);
                if (nv != m_a) begin qa.push_back('{cyc: cyc + 1, val: nv}); m_a = nv; end
                nv = next_val(m_b, 255, 1'b0, up_p[cyc], dn_p[cyc], cl_p[cyc]);
                if (nv != m_b) begin qb.push_back('{cyc: cyc + 1, val: nv}); m_b = nv; end
            end
        end
    end

    task automatic chk_state(input string nm, input int ea, input int eb);
        chk({nm, "_cnt_a"}, int'(cnt_a), ea);
        chk({nm, "_cnt_b"}, int'(cnt_b), eb);
        chk({nm, "_max_a"}, int'(amax_a), int'(ea == 99));
        chk({nm, "_min_a"}, int'(amin_a), int'(ea == 0));
        chk({nm, "_max_b"}, int'(amax_b), int'(eb == 255));
        chk({nm, "_min_b"}, int'(amin_b), int'(eb == 0));
    endtask

    vec_t vecs[11];
    int   n0, n2;

    initial begin
        vecs[0]  = '{3'b001,    6,  1,   1};  // clean up press
        vecs[1]  = '{3'b001,    3,  1,   1};  // 3-cycle glitch
        vecs[2]  = '{3'b001,   50,  6,   6};  // auto-repeat: 5 steps
        vecs[3]  = '{3'b100,    6,  0,   0};  // clear
        vecs[4]  = '{3'b010,    6, 99,   0};  // down at 0: wrap / saturate
        vecs[5]  = '{3'b011,    6, 99,   0};  // up+down together
        vecs[6]  = '{3'b001,    6,  0,   1};  // up at 99 wraps
        vecs[7]  = '{3'b001, 2100, 61, 255};  // 261 steps
        vecs[8]  = '{3'b001,    6, 62, 255};  // saturate at 255
        vecs[9]  = '{3'b010,    6, 61, 254};
        vecs[10] = '{3'b101,    6,  0,   0};  // clear beats up

        repeat (3) @(posedge clk);
        #1;
        chk_state("reset", 0, 0);
        chk("reset_step_a", int'(step_a), 0);
        chk("reset_step_b", int'(step_b), 0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            press(vecs[i].m, vecs[i].len);
            repeat (25) @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b);
        end

        // Clear mid auto-repeat at 42, then reset while up is still held.
        @(posedge clk); #1;
        n0 = cyc + 1;
        btn_up = 1'b1;
        mark(0, n0, 400);
        repeat (344) @(posedge clk);
        #1;
        btn_clr = 1'b1;
        mark(2, cyc + 1, 6);
        repeat (6) @(posedge clk);
        #1;
        btn_clr = 1'b0;
        chk_state("pre_clr", 42, 42);
        repeat (2) @(posedge clk);
        #1;
        chk_state("post_clr", 0, 0);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete(); qb.delete();
        m_a = 0; m_b = 0;
        for (int e = cyc; e < NCYC; e++) begin up_p[e] = 1'b0; dn_p[e] = 1'b0; cl_p[e] = 1'b0; end
        #1;
        chk_state("async_rst", 0, 0);
        chk("async_rst_step_a", int'(step_a), 0);
        chk("async_rst_step_b", int'(step_b), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        n2 = cyc + 1;
        mark(0, n2, 12);
        repeat (12) @(posedge clk);
        #1;
        btn_up = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk_state("after_rst_hold", 1, 1);
        chk("sb_drained_a", qa.size(), 0);
        chk("sb_drained_b", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
